// File: rtl/glitc_i2c_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : glitc_i2c_responder
// Description : I2C target with an 8 x 8-bit register file. The master writes
//               a 3-bit register pointer and then data bytes, or reads bytes
//               from the pointer. The pointer auto-increments and wraps 7 -> 0.
//               SCL and SDA are sampled asynchronously and resynchronised to
//               user_clk_i.
// Ports       : user_clk_i   - system clock, rising edge
//               user_rst_n_i - synchronous active-low reset
//               scl_i, sda_i - raw I2C pad levels, asynchronous
//               sda_o        - SDA pad output value, constant 0
//               sda_oen_o    - SDA output enable, active-low
//               reg_dat_o    - flattened register file, byte n = register n
//               wr_stb_o     - one-cycle pulse on a register write
//               wr_adr_o     - index of the written register
//               busy_o       - addressed transaction in progress
// Revision    : 1.0 - initial release
// ============================================================================
module glitc_i2c_responder #(
  parameter logic [6:0]  I2C_ADDR  = 7'h60,
  parameter logic [63:0] RESET_VAL = 64'h0
) (
  input  logic        user_clk_i,
  input  logic        user_rst_n_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_oen_o,
  output logic [63:0] reg_dat_o,
  output logic        wr_stb_o,
  output logic [2:0]  wr_adr_o,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8
  } state_t;

  // Synchronizer chain and history flops
  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  state_t      state_q,   state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q,   shift_d;
  logic [2:0]  ptr_q,     ptr_d;
  logic        rw_q,      rw_d;
  logic [63:0] regs_q,    regs_d;
  logic        sda_oen_q, sda_oen_d;
  logic        wr_stb_q,  wr_stb_d;
  logic [2:0]  wr_adr_q,  wr_adr_d;
  logic        busy_q,    busy_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;
  logic [2:0] ptr_inc;

  assign scl_rise  =  scl_sync_q & ~scl_hist_q;
  assign scl_fall  = ~scl_sync_q &  scl_hist_q;
  // SCL must be high on both the current and previous sample so that an SDA
  // change landing on the same cycle as an SCL edge is not taken as START/STOP.
  assign start_det =  scl_sync_q & scl_hist_q &  sda_hist_q & ~sda_sync_q;
  assign stop_det  =  scl_sync_q & scl_hist_q & ~sda_hist_q &  sda_sync_q;
  assign rx_byte   = {shift_q[6:0], sda_sync_q};
  assign ptr_inc   = ptr_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    regs_d    = regs_q;
    sda_oen_d = sda_oen_q;
    wr_stb_d  = 1'b0;
    wr_adr_d  = wr_adr_q;
    busy_d    = busy_q;

    if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      sda_oen_d = 1'b1;
      busy_d    = 1'b0;
    end else if (start_det) begin
      // Also covers repeated START; busy is kept until the address is judged.
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_oen_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oen_d = 1'b1;
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == I2C_ADDR) begin
                state_d = ST_ADDR_ACK;
                rw_d    = rx_byte[0];
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        // Ack phases: the first SCL fall (SDA still released) starts driving
        // the ACK low, the second one ends the 9th clock.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (sda_oen_q) begin
              sda_oen_d = 1'b0;
            end else if (rw_q) begin
              state_d   = ST_RDATA;
              bit_cnt_d = 3'd0;
              shift_d   = regs_q[{ptr_q, 3'b000} +: 8];
              sda_oen_d = regs_q[{ptr_q, 3'b000} + 6'd7];
            end else begin
              state_d   = ST_PTR;
              bit_cnt_d = 3'd0;
              sda_oen_d = 1'b1;
            end
          end
        end

        ST_PTR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d   = rx_byte[2:0];
              state_d = ST_PTR_ACK;
            end
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (sda_oen_q) begin
              sda_oen_d = 1'b0;
            end else begin
              state_d   = ST_WDATA;
              bit_cnt_d = 3'd0;
              sda_oen_d = 1'b1;
            end
          end
        end

        ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              regs_d[{ptr_q, 3'b000} +: 8] = rx_byte;
              wr_stb_d = 1'b1;
              wr_adr_d = ptr_q;
              ptr_d    = ptr_inc;
              state_d  = ST_WDATA_ACK;
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_RDATA_ACK;
            end
          end else if (scl_fall) begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oen_d = shift_q[6];
          end
        end

        // bit_cnt 0: releasing / waiting for the master's ACK bit;
        // bit_cnt 1: ACK seen, next byte preloaded, drive its MSB on SCL fall.
        ST_RDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oen_d = 1'b1;
            end else begin
              state_d   = ST_RDATA;
              bit_cnt_d = 3'd0;
              sda_oen_d = shift_q[7];
            end
          end else if (scl_rise && (bit_cnt_q == 3'd0)) begin
            ptr_d = ptr_inc;
            if (!sda_sync_q) begin
              shift_d   = regs_q[{ptr_inc, 3'b000} +: 8];
              bit_cnt_d = 3'd1;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end
        end

        default: begin
          state_d   = ST_IDLE;
          sda_oen_d = 1'b1;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge user_clk_i) begin
    if (!user_rst_n_i) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      ptr_q      <= 3'd0;
      rw_q       <= 1'b0;
      regs_q     <= RESET_VAL;
      sda_oen_q  <= 1'b1;
      wr_stb_q   <= 1'b0;
      wr_adr_q   <= 3'd0;
      busy_q     <= 1'b0;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      regs_q     <= regs_d;
      sda_oen_q  <= sda_oen_d;
      wr_stb_q   <= wr_stb_d;
      wr_adr_q   <= wr_adr_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_o     = 1'b0;
  assign sda_oen_o = sda_oen_q;
  assign reg_dat_o = regs_q;
  assign wr_stb_o  = wr_stb_q;
  assign wr_adr_o  = wr_adr_q;
  assign busy_o    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_glitc_i2c_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_glitc_i2c_responder
// Description : Directed bench for glitc_i2c_responder. A behavioural I2C
//               master drives an open-drain SDA line; every scenario is
//               repeated at 400 kHz and 100 kHz SCL with 0-2 clock SDA skew.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glitc_i2c_responder;

  localparam logic [63:0] RV       = 64'h8877665544332211;
  localparam logic [63:0] RV_WR    = 64'h8877665AA5332211;
  localparam logic [63:0] RV_RST_W = 64'h88773C5544332211;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_line;
  logic        sda_o, sda_oen_o, wr_stb_o, busy_o;
  logic [63:0] reg_dat_o;
  logic [2:0]  wr_adr_o;

  int n_vec = 0;
  int n_err = 0;
  int q_ns  = 625;
  int stb_q[$];
  int oen_low_cnt = 0;

  // Open-drain bus: either side can pull low.
  assign sda_line = m_sda & (sda_oen_o | sda_o);

  glitc_i2c_responder #(
    .I2C_ADDR  (7'h60),
    .RESET_VAL (RV)
  ) dut (
    .user_clk_i   (clk),
    .user_rst_n_i (rst_n),
    .scl_i        (m_scl),
    .sda_i        (sda_line),
    .sda_o        (sda_o),
    .sda_oen_o    (sda_oen_o),
    .reg_dat_o    (reg_dat_o),
    .wr_stb_o     (wr_stb_o),
    .wr_adr_o     (wr_adr_o),
    .busy_o       (busy_o)
  );

  initial forever #25 clk = ~clk;   // 20 MHz

  always @(negedge clk) begin
    if (wr_stb_o) stb_q.push_back(int'(wr_adr_o));
    if (!sda_oen_o) oen_low_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (q=%0d ns)", tag, obs, exp, q_ns);
    end
  endtask

  task automatic bit_cycle(input logic b, output logic rd);
    #($urandom_range(0, 2) * 50);
    m_sda = b;
    #(q_ns); m_scl = 1'b1;
    #(q_ns); @(negedge clk); rd = sda_line;
    #(q_ns); m_scl = 1'b0;
    #(q_ns);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], d);
    bit_cycle(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, r);
      v[i] = r;
    end
    bit_cycle(nack, r);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #(q_ns);
    m_scl = 1'b1; #(q_ns);
    m_sda = 1'b0; #(q_ns);
    m_scl = 1'b0; #(q_ns);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #(q_ns);
    m_scl = 1'b1; #(q_ns);
    m_sda = 1'b1; #(q_ns);
  endtask

  initial begin
    logic       a;
    logic [7:0] v;
    int         base;
    int         olow;

    for (int s = 0; s < 2; s++) begin
      q_ns = (s == 0) ? 625 : 2500;   // 400 kHz, then 100 kHz

      // ---- reset state ----
      m_scl = 1'b1; m_sda = 1'b1;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_regs",  reg_dat_o, RV);
      chk("rst_oen",   sda_oen_o, 1'b1);
      chk("rst_stb",   wr_stb_o,  1'b0);
      chk("rst_adr",   wr_adr_o,  3'd0);
      chk("rst_busy",  busy_o,    1'b0);
      chk("rst_sda_o", sda_o,     1'b0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // ---- write 0xA5, 0x5A to reg3, reg4 ----
      base = stb_q.size();
      i2c_start();
      send_byte(8'hC0, a); chk("wr_ack_addr", a, 1'b0);
      send_byte(8'h03, a); chk("wr_ack_ptr",  a, 1'b0);
      send_byte(8'hA5, a); chk("wr_ack_d0",   a, 1'b0);
      send_byte(8'h5A, a); chk("wr_ack_d1",   a, 1'b0);
      @(negedge clk);
      chk("wr_busy", busy_o, 1'b1);
      i2c_stop();
      repeat (8) @(negedge clk);
      chk("wr_busy_stop", busy_o, 1'b0);
      chk("wr_regs", reg_dat_o, RV_WR);
      chk("wr_nstb", stb_q.size() - base, 2);
      if (stb_q.size() - base == 2) begin
        chk("wr_adr0", stb_q[base],     3);
        chk("wr_adr1", stb_q[base + 1], 4);
      end

      // ---- pointer 7, repeated START, read 2 bytes with wrap ----
      base = stb_q.size();
      i2c_start();
      send_byte(8'hC0, a); chk("rd_ack_addr", a, 1'b0);
      send_byte(8'h07, a); chk("rd_ack_ptr",  a, 1'b0);
      i2c_start();
      send_byte(8'hC1, a); chk("rd_ack_raddr", a, 1'b0);
      recv_byte(1'b0, v);  chk("rd_reg7", v, 8'h88);
      recv_byte(1'b1, v);  chk("rd_reg0", v, 8'h11);
      @(negedge clk);
      chk("rd_busy_nack", busy_o, 1'b0);
      i2c_stop();
      // pointer should now be 1: read without a pointer write
      i2c_start();
      send_byte(8'hC1, a); chk("rd2_ack_addr", a, 1'b0);
      recv_byte(1'b1, v);  chk("rd2_reg1", v, 8'h22);
      i2c_stop();
      repeat (8) @(negedge clk);
      chk("rd_nstb", stb_q.size() - base, 0);

      // ---- address mismatch ----
      base = stb_q.size();
      olow = oen_low_cnt;
      i2c_start();
      send_byte(8'hA0, a); chk("mm_nack_addr", a, 1'b1);
      @(negedge clk);
      chk("mm_busy", busy_o, 1'b0);
      send_byte(8'h00, a); chk("mm_nack_d", a, 1'b1);
      i2c_stop();
      repeat (8) @(negedge clk);
      chk("mm_oen_never_low", oen_low_cnt - olow, 0);
      chk("mm_nstb", stb_q.size() - base, 0);
      chk("mm_busy_end", busy_o, 1'b0);

      // ---- aborted write to reg2 ----
      base = stb_q.size();
      i2c_start();
      send_byte(8'hC0, a); chk("ab_ack_addr", a, 1'b0);
      send_byte(8'h02, a); chk("ab_ack_ptr",  a, 1'b0);
      for (int i = 0; i < 4; i++) bit_cycle(1'b1, a);
      i2c_stop();
      repeat (8) @(negedge clk);
      chk("ab_regs", reg_dat_o, RV_WR);
      chk("ab_nstb", stb_q.size() - base, 0);
      chk("ab_busy", busy_o, 1'b0);

      // ---- reset while the target drives a 0 data bit ----
      i2c_start();
      send_byte(8'hC0, a); chk("rr_ack_addr", a, 1'b0);
      send_byte(8'h00, a); chk("rr_ack_ptr",  a, 1'b0);
      i2c_start();
      send_byte(8'hC1, a); chk("rr_ack_raddr", a, 1'b0);
      @(negedge clk);
      chk("rr_drive_bit7", sda_oen_o, 1'b0);   // reg0 = 0x11, MSB 0
      rst_n = 1'b0;
      @(negedge clk);
      chk("rr_oen_release", sda_oen_o, 1'b1);
      chk("rr_busy", busy_o, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rr_regs", reg_dat_o, RV);
      repeat (4) @(negedge clk);
      base = stb_q.size();
      i2c_start();
      send_byte(8'hC0, a); chk("rr_w_ack_addr", a, 1'b0);
      send_byte(8'h05, a); chk("rr_w_ack_ptr",  a, 1'b0);
      send_byte(8'h3C, a); chk("rr_w_ack_d",    a, 1'b0);
      i2c_stop();
      repeat (8) @(negedge clk);
      chk("rr_w_regs", reg_dat_o, RV_RST_W);
      chk("rr_w_nstb", stb_q.size() - base, 1);
      if (stb_q.size() - base == 1) chk("rr_w_adr", stb_q[base], 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/glitc_i2c_responder.md
GLITC_I2C_RESPONDER -- requirements
Module: glitc_i2c_responder

Interface
REQ-001 Parameter I2C_ADDR, default 7'h60, is the 7-bit target address this block answers to.
REQ-002 Parameter RESET_VAL, default 64'h0, holds the register file power-on/reset contents; byte n is RESET_VAL[8n+7:8n].
REQ-003 user_clk_i  input  1  the single system clock; all logic is on its rising edge.
REQ-004 user_rst_n_i  input  1  reset, synchronous and active-low.
REQ-005 scl_i  input  1  raw I2C SCL pad level; asynchronous to user_clk_i.
REQ-006 sda_i  input  1  raw I2C SDA pad level; asynchronous to user_clk_i.
REQ-007 sda_o  output  1  SDA pad output value; tied 0.
REQ-008 sda_oen_o  output  1  SDA output enable, active-low; 0 pulls SDA low, 1 releases it.
REQ-009 reg_dat_o  output  64  flattened register file; byte n is register n, n = 0..7.
REQ-010 wr_stb_o  output  1  one-cycle pulse when an I2C write updates a register.
REQ-011 wr_adr_o  output  3  index of the register updated; valid while wr_stb_o=1.
REQ-012 busy_o  output  1  high from an address-matched START until the next STOP or NACK-terminated read.

Function
REQ-013 scl_i and sda_i shall each pass through a 2-flop synchronizer followed by a 1-flop history register; all edges are detected on the synchronized signals.
REQ-014 START = synchronized SDA falls while SCL is high; STOP = synchronized SDA rises while SCL is high.
REQ-015 The block shall sample SDA on each synchronized SCL rising edge, MSB first.
REQ-016 The block shall change sda_oen_o only on the cycle after a synchronized SCL falling edge.
REQ-017 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-018 START in any state -> ADDR with bit counter = 0; this covers repeated START.
REQ-019 STOP in any state -> IDLE with SDA released.
REQ-020 ADDR: shift in 8 bits.
  - addr[7:1]==I2C_ADDR -> ADDR_ACK.
  - Mismatch -> IDLE; SDA is never driven.
REQ-021 ADDR_ACK: drive SDA low for the 9th clock, releasing after its SCL falling edge.
  - R/W=0 -> PTR.
  - R/W=1 -> RDATA, loading the shift register with register[ptr].
REQ-022 PTR: 8 bits received; ptr <= byte[2:0] (bits 7:3 ignored); ACK it -> WDATA.
REQ-023 WDATA: on the 8th bit, register[ptr] <= byte, wr_stb_o=1 for one cycle with wr_adr_o=ptr, then ACK -> WDATA_ACK -> WDATA, with ptr incremented.
REQ-024 RDATA: drive each bit with sda_oen_o = bit value (0 bit -> drive low, 1 -> release); after 8 bits release SDA -> RDATA_ACK.
REQ-025 RDATA_ACK: sample the master's ACK on the 9th SCL rising edge.
  - Low (ACK): ptr increments, load register[ptr+1] -> RDATA.
  - High (NACK): -> IDLE.
REQ-026 ptr is 3 bits and wraps 7 -> 0 on increment for both reads and writes.
REQ-027 ptr persists across transactions; a read without a preceding pointer write starts at the last ptr.
REQ-028 A write byte that is interrupted by START/STOP before its 8th bit shall not update any register.
REQ-029 When a register write and a reset occur in the same cycle, reset wins.
REQ-030 Latency: a register write is visible on reg_dat_o one user_clk_i cycle after the synchronized 8th SCL rising edge.

Reset
REQ-031 While user_rst_n_i=0 on a clock edge, the block shall apply:
  - state=IDLE, ptr=0, registers=RESET_VAL;
  - sda_oen_o=1, wr_stb_o=0, wr_adr_o=0, busy_o=0;
  - synchronizers loaded to 1.
REQ-032 Reset asserted mid-transaction shall release SDA on the next clock edge; the block ignores bus activity until the next START.
REQ-033 sda_o shall be 0 at all times, including during reset.

Verification
REQ-034 Write: START, 0xC0, 0x03, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; reg3=0xA5, reg4=0x5A; two wr_stb_o pulses with wr_adr_o=3 then 4.
REQ-035 Read: START, 0xC0, 0x07, repeated START, 0xC1, read 2 bytes (ACK, then NACK), STOP -> data = reg7 then reg0 (wrap); ptr=1 afterwards.
REQ-036 Address mismatch: START, 0xA0, 0x00, STOP -> sda_oen_o stays 1 throughout, no wr_stb_o pulse, busy_o=0.
REQ-037 Aborted write: START, 0xC0, 0x02, 4 bits of 0xF, STOP -> reg2 unchanged, no strobe for reg2, FSM=IDLE.
REQ-038 Reset mid-read: assert user_rst_n_i=0 while driving a 0 data bit -> sda_oen_o=1 next cycle; reg_dat_o=RESET_VAL; the next valid transaction completes normally.
REQ-039 Run all scenarios with SCL at 100 kHz and 400 kHz, user_clk_i ≥ 20 MHz, and random skew of 0-2 clocks between SCL and SDA edges; results shall be identical.
